// File: rtl/bmu_req_sched.sv
// Request scheduler in front of a fixed-latency BMU: per-channel request FIFOs,
// credit-gated round-robin issue, a channel tag pipeline and a response FIFO.
module bmu_req_sched #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 32,
  parameter int AP_W      = 24,
  parameter int DEPTH     = 4,
  parameter int LAT       = 1,
  parameter int RSP_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstL,
  input  logic [NUM_CH-1:0]         reqValid,
  output logic [NUM_CH-1:0]         reqReady,
  input  logic [NUM_CH*WIDTH-1:0]   reqA,
  input  logic [NUM_CH*WIDTH-1:0]   reqB,
  input  logic [NUM_CH*AP_W-1:0]    reqAp,
  output logic                      validIn,
  output logic [WIDTH-1:0]          aIn,
  output logic [WIDTH-1:0]          bIn,
  output logic [AP_W-1:0]           ap,
  input  logic [WIDTH-1:0]          resultFf,
  input  logic                      error,
  output logic                      rspValid,
  input  logic                      rspReady,
  output logic [$clog2(NUM_CH)-1:0] rspChan,
  output logic [WIDTH-1:0]          rspData,
  output logic                      rspErr,
  output logic [15:0]               errCnt
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RPTR_W = $clog2(RSP_DEPTH);
  localparam int RCNT_W = RPTR_W + 1;

  // ---------------------------------------------------------------------------
  // Per-channel request FIFOs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_qa  [NUM_CH][DEPTH];
  logic [WIDTH-1:0] r_qb  [NUM_CH][DEPTH];
  logic [AP_W-1:0]  r_qap [NUM_CH][DEPTH];
  logic [PTR_W-1:0] r_qwp [NUM_CH];
  logic [PTR_W-1:0] r_qrp [NUM_CH];
  logic [CNT_W-1:0] r_qcnt[NUM_CH];
  logic             r_rdy_en;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_nempty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;

  logic            w_found;
  logic            w_credit_ok;
  logic            w_issue;
  logic [CH_W-1:0] w_grant;
  logic [CH_W-1:0] r_last;

  // r_rdy_en holds ready low through reset and for the cycle it is released in
  assign reqReady = {NUM_CH{r_rdy_en}} & ~w_full;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_full[i]   = (r_qcnt[i] == CNT_W'(DEPTH));
      w_nempty[i] = (r_qcnt[i] != '0);
      w_push[i]   = reqValid[i] & reqReady[i];
      w_pop[i]    = w_issue && (w_grant == CH_W'(i));
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and counts alone define
  // which entries are valid, so the data can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) begin
        r_qa[i][r_qwp[i]]  <= reqA[i*WIDTH +: WIDTH];
        r_qb[i][r_qwp[i]]  <= reqB[i*WIDTH +: WIDTH];
        r_qap[i][r_qwp[i]] <= reqAp[i*AP_W +: AP_W];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_rdy_en <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_qwp[i]  <= '0;
        r_qrp[i]  <= '0;
        r_qcnt[i] <= '0;
      end
    end else begin
      r_rdy_en <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) r_qwp[i] <= r_qwp[i] + 1'b1;
        if (w_pop[i])  r_qrp[i] <= r_qrp[i] + 1'b1;
        case ({w_push[i], w_pop[i]})
          2'b10:   r_qcnt[i] <= r_qcnt[i] + 1'b1;
          2'b01:   r_qcnt[i] <= r_qcnt[i] - 1'b1;
          default: r_qcnt[i] <= r_qcnt[i];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration with response credit
  // ---------------------------------------------------------------------------
  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] last, input int k);
    int s;
    s = int'(last) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // NOTE: every variable written here gets a default first, so no latch forms.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!w_found && w_nempty[rr_idx(r_last, k)]) begin
        w_found = 1'b1;
        w_grant = rr_idx(r_last, k);
      end
    end
  end

  logic [RCNT_W-1:0] r_inflight;
  logic [RCNT_W-1:0] r_rcnt;

  // Credit covers both results still in the BMU and results already queued
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_rcnt}) < (RCNT_W+1)'(RSP_DEPTH);
  assign w_issue     = w_found & w_credit_ok;

  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [AP_W-1:0]  w_head_ap;

  assign w_head_a  = r_qa[w_grant][r_qrp[w_grant]];
  assign w_head_b  = r_qb[w_grant][r_qrp[w_grant]];
  assign w_head_ap = r_qap[w_grant][r_qrp[w_grant]];

  // ---------------------------------------------------------------------------
  // Issue registers
  // ---------------------------------------------------------------------------
  logic             r_valid_in;
  logic [WIDTH-1:0] r_a_in;
  logic [WIDTH-1:0] r_b_in;
  logic [AP_W-1:0]  r_ap;
  logic [CH_W-1:0]  r_issue_chan;

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_valid_in   <= 1'b0;
      r_a_in       <= '0;
      r_b_in       <= '0;
      r_ap         <= '0;
      r_issue_chan <= '0;
      r_last       <= CH_W'(NUM_CH - 1);
    end else begin
      r_valid_in <= w_issue;
      if (w_issue) begin
        r_a_in       <= w_head_a;
        r_b_in       <= w_head_b;
        r_ap         <= w_head_ap;
        r_issue_chan <= w_grant;
        r_last       <= w_grant;
      end
    end
  end

  assign validIn = r_valid_in;
  assign aIn     = r_a_in;
  assign bIn     = r_b_in;
  assign ap      = r_ap;

  // ---------------------------------------------------------------------------
  // Tag pipeline: stage LAT-1 is valid in the cycle the BMU result is present
  // ---------------------------------------------------------------------------
  logic [LAT-1:0]  r_pv;
  logic [CH_W-1:0] r_pc [LAT];

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_pv <= '0;
      for (int k = 0; k < LAT; k++) r_pc[k] <= '0;
    end else begin
      r_pv[0] <= r_valid_in;
      r_pc[0] <= r_issue_chan;
      for (int k = 1; k < LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pc[k] <= r_pc[k-1];
      end
    end
  end

  logic w_rsp_push;
  logic w_rsp_pop;

  assign w_rsp_push = r_pv[LAT-1];
  assign w_rsp_pop  = rspValid & rspReady;

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_rsp_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]   r_rchan [RSP_DEPTH];
  logic [WIDTH-1:0]  r_rdata [RSP_DEPTH];
  logic              r_rerr  [RSP_DEPTH];
  logic [RPTR_W-1:0] r_rwp;
  logic [RPTR_W-1:0] r_rrp;
  logic [15:0]       r_err_cnt;

  always_ff @(posedge clk) begin
    if (w_rsp_push) begin
      r_rchan[r_rwp] <= r_pc[LAT-1];
      r_rdata[r_rwp] <= resultFf;
      r_rerr[r_rwp]  <= error;
    end
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_rwp     <= '0;
      r_rrp     <= '0;
      r_rcnt    <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_rsp_push) r_rwp <= r_rwp + 1'b1;
      if (w_rsp_pop)  r_rrp <= r_rrp + 1'b1;
      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rcnt <= r_rcnt + 1'b1;
        2'b01:   r_rcnt <= r_rcnt - 1'b1;
        default: r_rcnt <= r_rcnt;
      endcase
      if (w_rsp_pop && rspErr && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign rspValid = (r_rcnt != '0);
  assign rspChan  = r_rchan[r_rrp];
  assign rspData  = r_rdata[r_rrp];
  assign rspErr   = r_rerr[r_rrp];
  assign errCnt   = r_err_cnt;

  // The credit check must keep a push into a full FIFO from ever lacking a pop
  always @(posedge clk) begin
    if (rstL) begin
      a_rsp_no_overflow: assert (!(w_rsp_push && !w_rsp_pop && (r_rcnt == RCNT_W'(RSP_DEPTH))));
    end
  end

endmodule

// File: tb/tb_bmu_req_sched.sv
// Directed self-checking bench for bmu_req_sched with default parameters and a
// one-cycle BMU model (result = a >> b, error = ap[23]).
module tb_bmu_req_sched;

  logic         clk;
  logic         rstL;
  logic [3:0]   reqValid;
  logic [3:0]   reqReady;
  logic [127:0] reqA;
  logic [127:0] reqB;
  logic [95:0]  reqAp;
  logic         validIn;
  logic [31:0]  aIn;
  logic [31:0]  bIn;
  logic [23:0]  ap;
  logic [31:0]  resultFf;
  logic         error;
  logic         rspValid;
  logic         rspReady;
  logic [1:0]   rspChan;
  logic [31:0]  rspData;
  logic         rspErr;
  logic [15:0]  errCnt;

  int checks = 0;
  int errors = 0;

  bmu_req_sched dut (
    .clk      (clk),
    .rstL     (rstL),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqA     (reqA),
    .reqB     (reqB),
    .reqAp    (reqAp),
    .validIn  (validIn),
    .aIn      (aIn),
    .bIn      (bIn),
    .ap       (ap),
    .resultFf (resultFf),
    .error    (error),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspChan  (rspChan),
    .rspData  (rspData),
    .rspErr   (rspErr),
    .errCnt   (errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle BMU: result for the op seen in cycle c is presented in cycle c+1
  always @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      resultFf <= '0;
      error    <= 1'b0;
    end else if (validIn) begin
      resultFf <= aIn >> bIn[4:0];
      error    <= ap[23];
    end
  end

  // Issue / response logs, sampled mid-cycle
  int          cyc = 0;
  int          n_issue = 0;
  int          n_resp = 0;
  logic [23:0] iss_ap   [256];
  int          iss_cyc  [256];
  int          rsp_chan [256];
  logic [31:0] rsp_data [256];
  logic        rsp_err  [256];

  always @(negedge clk) begin
    cyc++;
    if (validIn === 1'b1) begin
      iss_ap[n_issue % 256]  = ap;
      iss_cyc[n_issue % 256] = cyc;
      n_issue++;
    end
    if (rspValid === 1'b1 && rspReady === 1'b1) begin
      rsp_chan[n_resp % 256] = int'(rspChan);
      rsp_data[n_resp % 256] = rspData;
      rsp_err[n_resp % 256]  = rspErr;
      n_resp++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int ch, input logic [31:0] a, input logic [31:0] b,
                         input logic [23:0] apv);
    reqA[ch*32 +: 32]  = a;
    reqB[ch*32 +: 32]  = b;
    reqAp[ch*24 +: 24] = apv;
  endtask

  task automatic do_reset();
    rstL     = 1'b0;
    reqValid = '0;
    rspReady = 1'b0;
    tick(2);
    rstL = 1'b1;
    tick(1);
  endtask

  initial begin
    int bi, br, c0, idx;
    logic rdy;

    rstL     = 1'b0;
    reqValid = '0;
    reqA     = '0;
    reqB     = '0;
    reqAp    = '0;
    rspReady = 1'b0;
    tick(2);

    // Reset state
    check("rst_reqReady", reqReady, 4'h0);
    check("rst_validIn",  validIn,  1'b0);
    check("rst_aIn",      aIn,      32'h0);
    check("rst_bIn",      bIn,      32'h0);
    check("rst_ap",       ap,       24'h0);
    check("rst_rspValid", rspValid, 1'b0);
    check("rst_errCnt",   errCnt,   16'h0);

    rstL = 1'b1;
    check("rel_ready_low", reqReady, 4'h0);
    tick(1);
    check("rel_ready_up", reqReady, 4'hF);

    // Single op on channel 2: 0xF0 >> 4 = 0x0F
    set_req(2, 32'h0000_00F0, 32'h4, 24'h000020);
    reqValid = 4'b0100;
    tick(1);
    reqValid = '0;
    check("single_no_bypass", validIn, 1'b0);
    tick(1);
    check("single_validIn", validIn, 1'b1);
    check("single_aIn",     aIn,     32'hF0);
    check("single_bIn",     bIn,     32'h4);
    check("single_ap",      ap,      24'h000020);
    check("single_rsp_early", rspValid, 1'b0);
    tick(1);
    check("single_vi_drop", validIn,  1'b0);
    check("single_aIn_hold", aIn,     32'hF0);
    check("single_rsp_e2",  rspValid, 1'b0);
    tick(1);
    check("single_rspValid", rspValid, 1'b1);
    check("single_rspChan",  rspChan,  2'd2);
    check("single_rspData",  rspData,  32'h0F);
    check("single_rspErr",   rspErr,   1'b0);
    rspReady = 1'b1;
    tick(1);
    check("single_popped", rspValid, 1'b0);

    // Fairness: 3 requests per channel, round-robin from channel 0
    do_reset();
    rspReady = 1'b1;
    bi = n_issue;
    br = n_resp;
    for (int j = 0; j < 3; j++) begin
      for (int ch = 0; ch < 4; ch++)
        set_req(ch, 32'h100 * ch + j, 32'h0, 24'(ch * 16 + j));
      reqValid = 4'hF;
      tick(1);
    end
    reqValid = '0;
    for (int k = 0; k < 40 && (n_resp - br) < 12; k++) tick(1);
    check("fair_issue_cnt", n_issue - bi, 12);
    check("fair_rsp_cnt",   n_resp - br,  12);
    for (int i = 0; i < 12; i++) begin
      check("fair_order", iss_ap[(bi + i) % 256][7:4], i % 4);
      check("fair_no_idle", iss_cyc[(bi + i) % 256], iss_cyc[bi % 256] + i);
      check("fair_rsp_chan", rsp_chan[(br + i) % 256], i % 4);
      check("fair_rsp_data", rsp_data[(br + i) % 256], 32'h100 * (i % 4) + i / 4);
    end

    // Backpressure: 8 credits, then one pop frees exactly one issue
    do_reset();
    for (int ch = 0; ch < 4; ch++) set_req(ch, 32'h55, 32'h0, 24'h0);
    bi = n_issue;
    reqValid = 4'hF;
    tick(20);
    check("bp_issue_cnt", n_issue - bi, 8);
    check("bp_validIn",   validIn,  1'b0);
    check("bp_all_full",  reqReady, 4'h0);
    check("bp_rspValid",  rspValid, 1'b1);
    rspReady = 1'b1;
    tick(1);
    rspReady = 1'b0;
    check("bp_resume_wait", validIn, 1'b0);
    tick(1);
    check("bp_resume", validIn, 1'b1);
    tick(1);
    check("bp_stop_again", validIn, 1'b0);
    check("bp_issue_cnt2", n_issue - bi, 9);
    reqValid = '0;

    // Full FIFO: exhaust credit on ch1, then push 5 to ch0
    do_reset();
    set_req(1, 32'h11, 32'h0, 24'h000010);
    bi = n_issue;
    reqValid = 4'b0010;
    tick(14);
    reqValid = '0;
    check("ff_credit_used", n_issue - bi, 8);
    check("ff_ch1_full", reqReady[1], 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_req(0, 32'hA0 + k, 32'h0, 24'(k));
      reqValid = 4'b0001;
      check("ff_ready_k", reqReady[0], 1'b1);
      tick(1);
    end
    check("ff_full_ready", reqReady[0], 1'b0);
    check("ff_no_issue",   validIn,     1'b0);
    set_req(0, 32'hA4, 32'h0, 24'h4);
    tick(3);
    check("ff_held_ready", reqReady[0], 1'b0);
    br = n_resp;
    rspReady = 1'b1;
    rdy = 1'b0;
    for (int k = 0; k < 20 && !rdy; k++) begin
      rdy = reqReady[0];
      tick(1);
    end
    reqValid = '0;
    check("ff_5th_accepted", rdy, 1'b1);
    for (int k = 0; k < 80 && (n_resp - br) < 17; k++) tick(1);
    check("ff_rsp_cnt", n_resp - br, 17);
    c0 = 0;
    for (int i = 0; i < 17; i++) begin
      idx = (br + i) % 256;
      if (rsp_chan[idx] == 0) begin
        check("ff_ch0_order", rsp_data[idx], 32'hA0 + c0);
        c0++;
      end
    end
    check("ff_ch0_cnt", c0, 5);

    // Error counting and saturation
    do_reset();
    check("err_rst", errCnt, 16'h0);
    rspReady = 1'b1;
    br = n_resp;
    set_req(3, 32'h7, 32'h0, 24'h800000);
    reqValid = 4'b1000;
    tick(3);
    set_req(3, 32'h8, 32'h0, 24'h000000);
    tick(1);
    reqValid = '0;
    tick(10);
    check("err_rsp_cnt", n_resp - br, 4);
    check("err_flag_1",  rsp_err[br % 256], 1'b1);
    check("err_flag_0",  rsp_err[(br + 3) % 256], 1'b0);
    check("err_cnt3",    errCnt, 16'd3);
    set_req(3, 32'h9, 32'h0, 24'h800000);
    reqValid = 4'b1000;
    tick(65540);
    reqValid = '0;
    tick(10);
    check("err_saturate", errCnt, 16'hFFFF);

    // Reset with 2 ops in flight, 3 queued and one response pending
    do_reset();
    set_req(3, 32'h33, 32'h0, 24'h0);
    reqValid = 4'b1000;
    tick(1);
    reqValid = '0;
    tick(3);
    check("mid_rsp_pending", rspValid, 1'b1);
    for (int ch = 0; ch < 4; ch++) set_req(ch, 32'h40 + ch, 32'h0, 24'h0);
    reqValid = 4'hF;
    tick(1);
    reqValid = 4'b0001;
    tick(1);
    reqValid = '0;
    tick(1);
    check("mid_pre_validIn", validIn, 1'b1);
    rstL = 1'b0;
    #1;
    check("mid_validIn",  validIn,  1'b0);
    check("mid_rspValid", rspValid, 1'b0);
    check("mid_reqReady", reqReady, 4'h0);
    tick(2);
    rstL = 1'b1;
    rspReady = 1'b1;
    bi = n_issue;
    br = n_resp;
    tick(15);
    check("mid_no_issue", n_issue - bi, 0);
    check("mid_no_rsp",   n_resp - br,  0);
    check("mid_idle_rsp", rspValid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
